// File: rtl/adc_code_histogram_if.sv
// adc_code_histogram_if: sample-FIFO pop port and bin-dump stream of the histogrammer
interface adc_code_histogram_if #(
  parameter int CODE_W = 10,
  parameter int CNT_W  = 16
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [CODE_W-1:0] fifo_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [CODE_W-1:0] dump_addr;
  logic [CNT_W-1:0]  dump_count;
  logic              dump_last;
  modport master (
    input  fifo_empty, fifo_data, dump_ready,
    output fifo_rd_en, dump_valid, dump_addr, dump_count, dump_last
  );
  modport slave (
    output fifo_empty, fifo_data, dump_ready,
    input  fifo_rd_en, dump_valid, dump_addr, dump_count, dump_last
  );
endinterface

// File: rtl/adc_code_histogram.sv
// adc_code_histogram: pipelined saturating code-density histogram with clear sweep and streamed dump
module adc_code_histogram #(
  parameter int CODE_W        = 10,
  parameter int CNT_W         = 16,
  parameter int TOT_W         = 32,
  parameter int CLEAR_ON_DUMP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_clear,
  input  logic                 acq_en,
  input  logic                 dump_start,
  adc_code_histogram_if.master bus,
  output logic                 busy,
  output logic [TOT_W-1:0]     total_count,
  output logic                 sat_flag
);
  localparam int NBINS = 2**CODE_W;
  typedef enum logic [2:0] {CLEAR, IDLE, ACQ, DRAIN, DUMP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] mem [NBINS];
  logic [CNT_W-1:0] rdata, s2_old, s2_new, fwd_data, wdata;
  logic [CODE_W-1:0] clr_addr, s2_code, raddr, waddr;
  logic s1_v, s2_v, fwd, we, accept, rd_pend, dump_go;
  always_comb begin
    state_n = state;
    case (state)
      CLEAR:   state_n = clr_addr == CODE_W'(NBINS - 1) ? IDLE : CLEAR;
      IDLE:    state_n = start_clear ? CLEAR : dump_start ? DUMP : acq_en ? ACQ : IDLE;
      ACQ:     state_n = acq_en ? ACQ : DRAIN;
      DRAIN:   state_n = s1_v ? DRAIN : IDLE;
      DUMP:    state_n = accept && bus.dump_last ? IDLE : DUMP;
      default: state_n = CLEAR;
    endcase
  end
  assign busy           = state != IDLE;
  assign bus.fifo_rd_en = state == ACQ && acq_en && !bus.fifo_empty;
  assign accept         = bus.dump_valid && bus.dump_ready;
  assign dump_go        = state == IDLE && state_n == DUMP;
  assign raddr  = state == DUMP ? bus.dump_addr + CODE_W'(1) : state == IDLE ? '0 : bus.fifo_data;
  assign s2_old = fwd ? fwd_data : rdata;
  assign s2_new = &s2_old ? s2_old : s2_old + CNT_W'(1);
  assign we     = state == CLEAR || s2_v || (CLEAR_ON_DUMP != 0 && state == DUMP && accept);
  assign waddr  = state == CLEAR ? clr_addr : s2_v ? s2_code : bus.dump_addr;
  assign wdata  = s2_v ? s2_new : '0;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
  always_ff @(posedge clk) begin
    state    <= rst ? CLEAR : state_n;
    clr_addr <= rst || state != CLEAR ? '0 : clr_addr + CODE_W'(1);
  end
  always_ff @(posedge clk) begin
    s1_v     <= !rst && bus.fifo_rd_en;
    s2_v     <= !rst && s1_v;
    fwd      <= !rst && s2_v && s1_v && s2_code == bus.fifo_data;
    s2_code  <= bus.fifo_data;
    fwd_data <= s2_new;
  end
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      total_count <= '0;
      sat_flag    <= 1'b0;
    end else if (s2_v) begin
      total_count <= &total_count ? total_count : total_count + TOT_W'(1);
      sat_flag    <= sat_flag | (&s2_new);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend        <= 1'b0;
      bus.dump_valid <= 1'b0;
      bus.dump_last  <= 1'b0;
      bus.dump_addr  <= '0;
      bus.dump_count <= '0;
    end else begin
      rd_pend       <= dump_go || (accept && !bus.dump_last);
      bus.dump_addr <= dump_go ? '0 : accept && !bus.dump_last ? bus.dump_addr + CODE_W'(1) : bus.dump_addr;
      if (rd_pend) begin
        bus.dump_valid <= 1'b1;
        bus.dump_count <= rdata;
        bus.dump_last  <= &bus.dump_addr;
      end else if (accept) begin
        bus.dump_valid <= 1'b0;
        bus.dump_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_code_histogram.sv
// tb_adc_code_histogram: directed checks of a 16-bit and a saturating 4-bit clear-on-dump histogrammer
module tb_adc_code_histogram;
  localparam int NB = 1024;
  logic clk = 0, rst = 1, start_clear = 0, acq_en = 0, dump_start = 0, dready = 0;
  logic [9:0] fdata = '0;
  logic fempty;
  logic [9:0] fmem [256];
  int wr_ptr = 0, rd_ptr = 0, base = 0, n = 0;
  int mdl [NB];
  bit b_zero = 0;
  int checks = 0, errors = 0;
  logic busy_a, busy_b, sat_a, sat_b;
  logic [31:0] tot_a, tot_b;
  adc_code_histogram_if #(.CODE_W(10), .CNT_W(16)) a_if ();
  adc_code_histogram_if #(.CODE_W(10), .CNT_W(4))  b_if ();
  assign fempty = rd_ptr == wr_ptr;
  assign a_if.fifo_empty = fempty;
  assign b_if.fifo_empty = fempty;
  assign a_if.fifo_data  = fdata;
  assign b_if.fifo_data  = fdata;
  assign a_if.dump_ready = dready;
  assign b_if.dump_ready = dready;
  adc_code_histogram #(.CODE_W(10), .CNT_W(16), .TOT_W(32), .CLEAR_ON_DUMP(0)) dut_a (
    .clk(clk), .rst(rst), .start_clear(start_clear), .acq_en(acq_en), .dump_start(dump_start),
    .bus(a_if.master), .busy(busy_a), .total_count(tot_a), .sat_flag(sat_a));
  adc_code_histogram #(.CODE_W(10), .CNT_W(4), .TOT_W(32), .CLEAR_ON_DUMP(1)) dut_b (
    .clk(clk), .rst(rst), .start_clear(start_clear), .acq_en(acq_en), .dump_start(dump_start),
    .bus(b_if.master), .busy(busy_b), .total_count(tot_b), .sat_flag(sat_b));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (a_if.fifo_rd_en && rd_ptr < wr_ptr) begin
      fdata  <= fmem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) chk("pop_when_empty", 32'(a_if.fifo_rd_en & fempty), 0);
  task automatic push(input logic [9:0] c);
    fmem[wr_ptr] = c;
    wr_ptr++;
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic wait_idle(input string tag, input int max, output int cnt);
    cnt = 0;
    while (busy_a && cnt < max) begin
      @(negedge clk);
      cnt++;
    end
    chk(tag, 32'(busy_a), 0);
  endtask
  task automatic build_model();
    for (int i = 0; i < NB; i++) mdl[i] = 0;
    for (int i = base; i < rd_ptr; i++) mdl[fmem[i]]++;
  endtask
  task automatic dump(input bit tog);
    int idx = 0, t = 0, first = -1;
    bit r = 1;
    dump_start = 1;
    tick(1);
    dump_start = 0;
    while (idx < NB && t < 8000) begin
      if (a_if.dump_valid) begin
        if (first < 0) first = t;
        chk("dump_addr", 32'(a_if.dump_addr), idx);
        chk("dump_cnt_a", 32'(a_if.dump_count), mdl[idx] > 65535 ? 65535 : mdl[idx]);
        chk("dump_last", 32'(a_if.dump_last), 32'(idx == NB - 1));
        chk("dump_valid_b", 32'(b_if.dump_valid), 1);
        chk("dump_cnt_b", 32'(b_if.dump_count), b_zero ? 0 : mdl[idx] > 15 ? 15 : mdl[idx]);
      end
      r = tog ? ~r : 1'b1;
      dready = r;
      if (a_if.dump_valid && r) idx++;
      tick(1);
      t++;
    end
    dready = 0;
    chk("dump_beats", idx, NB);
    chk("first_valid_le2", 32'(first >= 0 && first <= 2), 1);
    chk("dump_end_idle", 32'(busy_a), 0);
  endtask
  initial begin
    tick(3);
    chk("rst_busy", 32'(busy_a), 1);
    chk("rst_valid", 32'(a_if.dump_valid), 0);
    chk("rst_last", 32'(a_if.dump_last), 0);
    chk("rst_addr", 32'(a_if.dump_addr), 0);
    chk("rst_count", 32'(a_if.dump_count), 0);
    chk("rst_total", tot_a, 0);
    chk("rst_sat", 32'(sat_a), 0);
    chk("rst_rd_en", 32'(a_if.fifo_rd_en), 0);
    rst = 0;
    wait_idle("clear_done", NB + 10, n);
    chk("clear_len", 32'(n >= NB && n <= NB + 2), 1);
    chk("clear_done_b", 32'(busy_b), 0);
    base = rd_ptr;
    build_model();
    dump(0);
    push(5); push(5); push(5); push(7);
    acq_en = 1;
    tick(10);
    acq_en = 0;
    wait_idle("acq_idle", 10, n);
    chk("popped_4", rd_ptr - base, 4);
    chk("total_4", tot_a, 4);
    chk("sat_a_4", 32'(sat_a), 0);
    repeat (20) push(3);
    acq_en = 1;
    tick(30);
    acq_en = 0;
    wait_idle("acq_idle2", 10, n);
    chk("total_24_a", tot_a, 24);
    chk("total_24_b", tot_b, 24);
    chk("sat_a_24", 32'(sat_a), 0);
    chk("sat_b_24", 32'(sat_b), 1);
    push(100); push(101); push(101); push(102); push(200); push(201);
    acq_en = 1;
    tick(4);
    acq_en = 0;
    chk("drop_pops", rd_ptr - base, 27);
    wait_idle("drain_idle", 10, n);
    chk("drain_len", 32'(n <= 2), 1);
    chk("drain_total", tot_a, 27);
    acq_en = 1;
    tick(10);
    acq_en = 0;
    wait_idle("acq_idle3", 10, n);
    chk("popped_30", rd_ptr - base, 30);
    chk("total_30", tot_a, 30);
    build_model();
    dump(1);
    b_zero = 1;
    chk("total_after_dump", tot_a, 30);
    dump(0);
    start_clear = 1;
    tick(1);
    start_clear = 0;
    chk("sc_busy", 32'(busy_a), 1);
    wait_idle("sc_done", NB + 10, n);
    chk("sc_total_a", tot_a, 0);
    chk("sc_total_b", tot_b, 0);
    chk("sc_sat_b", 32'(sat_b), 0);
    dump_start = 1;
    tick(1);
    dump_start = 0;
    dready = 1;
    tick(20);
    chk("pre_rst_dumping", 32'(busy_a), 1);
    rst = 1;
    tick(1);
    chk("rst_dump_valid_a", 32'(a_if.dump_valid), 0);
    chk("rst_dump_valid_b", 32'(b_if.dump_valid), 0);
    chk("rst_dump_busy", 32'(busy_a), 1);
    rst = 0;
    dready = 0;
    wait_idle("reclear_done", NB + 10, n);
    chk("reclear_len", 32'(n >= NB && n <= NB + 2), 1);
    chk("reclear_total", tot_a, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
